// File: rtl/seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_ctrl
// Purpose  : Instruction sequencer for the 8-bit uProcessor. Fetches opcode
//            and operand bytes over a req/valid handshake, drives the ALU
//            during EXEC, and writes results back to acc/carry/register file.
// Revision : 1.0 - initial release
// ============================================================================
module seq_ctrl #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  output logic       instr_req,
  output logic [7:0] instr_addr,
  input  logic       instr_valid,
  input  logic [7:0] instr_data,
  output logic [2:0] alu_code,
  output logic [7:0] alu_a,
  output logic [7:0] alu_r,
  output logic       alu_ci,
  input  logic [7:0] alu_out,
  input  logic       alu_co,
  output logic [7:0] acc_q,
  output logic       carry_q,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_OPER  = 2'd2,
    S_EXEC  = 2'd3
  } state_t;

  localparam logic [2:0] c_OP_ADD = 3'd0;
  localparam logic [2:0] c_OP_SUB = 3'd1;
  localparam logic [2:0] c_OP_LD  = 3'd6;
  localparam logic [2:0] c_OP_SYS = 3'd7;

  localparam logic [1:0] c_SYS_ST  = 2'd0;
  localparam logic [1:0] c_SYS_LDI = 2'd1;
  localparam logic [1:0] c_SYS_JMP = 2'd2;
  localparam logic [1:0] c_SYS_JC  = 2'd3;

  state_t     r_state;
  logic [7:0] r_pc;
  logic [7:0] r_acc;
  logic       r_carry;
  logic [7:0] r_ir;
  logic [7:0] r_opnd;
  logic [7:0] r_regs [8];
  logic       r_req;
  logic       r_busy;
  logic [2:0] r_alu_code;
  logic       r_alu_ci;

  // Decode of the held opcode and of the byte currently on the memory bus
  logic [2:0] w_op;
  logic [1:0] w_cs;
  logic [2:0] w_idx;
  logic [2:0] w_new_op;
  logic       w_new_two_byte;
  logic       w_new_addsub;
  logic       w_cap;

  assign w_op           = r_ir[7:5];
  assign w_cs           = r_ir[4:3];
  assign w_idx          = r_ir[2:0];
  assign w_new_op       = instr_data[7:5];
  assign w_new_two_byte = (w_new_op == c_OP_SYS) && (instr_data[4:3] != c_SYS_ST);
  assign w_new_addsub   = (w_new_op == c_OP_ADD) || (w_new_op == c_OP_SUB);
  // A byte is only taken while a request is outstanding; stray valids drop out here
  assign w_cap          = r_req & instr_valid;

  // Sequencer FSM: fetch/operand capture, writeback and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_acc      <= 8'h00;
      r_carry    <= 1'b0;
      r_ir       <= 8'h00;
      r_opnd     <= 8'h00;
      r_req      <= 1'b0;
      r_busy     <= 1'b0;
      r_alu_code <= c_OP_LD;
      r_alu_ci   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (run) begin
            r_state <= S_FETCH;
            r_req   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          if (w_cap) begin
            r_ir <= instr_data;
            r_pc <= r_pc + 8'd1;
            if (w_new_two_byte) begin
              r_state <= S_OPER;
            end else begin
              // ALU controls are set up on the way into EXEC so they are
              // registered outputs; system ops leave the ALU on its idle code
              r_state    <= S_EXEC;
              r_req      <= 1'b0;
              r_alu_code <= (w_new_op == c_OP_SYS) ? c_OP_LD : w_new_op;
              r_alu_ci   <= w_new_addsub & instr_data[4] & r_carry;
            end
          end
        end
        S_OPER: begin
          if (w_cap) begin
            r_opnd  <= instr_data;
            r_pc    <= r_pc + 8'd1;
            r_state <= S_EXEC;
            r_req   <= 1'b0;
          end
        end
        S_EXEC: begin
          if (w_op != c_OP_SYS) begin
            r_acc <= alu_out;
            if ((w_op == c_OP_ADD) || (w_op == c_OP_SUB)) begin
              r_carry <= alu_co;
            end
          end else begin
            case (w_cs)
              c_SYS_ST:  r_regs[w_idx] <= r_acc;
              c_SYS_LDI: r_acc <= r_opnd;
              c_SYS_JMP: r_pc  <= r_opnd;
              c_SYS_JC:  if (r_carry) r_pc <= r_opnd;
              default:   ;
            endcase
          end
          r_alu_code <= c_OP_LD;
          r_alu_ci   <= 1'b0;
          if (run) begin
            r_state <= S_FETCH;
            r_req   <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign instr_req  = r_req;
  assign instr_addr = r_pc;
  assign alu_code   = r_alu_code;
  assign alu_a      = r_acc;
  assign alu_r      = r_regs[w_idx];
  assign alu_ci     = r_alu_ci;
  assign acc_q      = r_acc;
  assign carry_q    = r_carry;
  assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_ctrl
// Purpose  : Self-checking bench for seq_ctrl with program memory, reference
//            ALU and a scoreboard of expected fetch addresses and results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       instr_req;
  logic [7:0] instr_addr;
  logic       instr_valid;
  logic [7:0] instr_data;
  logic [2:0] alu_code;
  logic [7:0] alu_a;
  logic [7:0] alu_r;
  logic       alu_ci;
  logic [7:0] alu_out;
  logic       alu_co;
  logic [7:0] acc_q;
  logic       carry_q;
  logic       busy;

  seq_ctrl #(.RESET_PC(8'h00)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .instr_req   (instr_req),
    .instr_addr  (instr_addr),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .alu_code    (alu_code),
    .alu_a       (alu_a),
    .alu_r       (alu_r),
    .alu_ci      (alu_ci),
    .alu_out     (alu_out),
    .alu_co      (alu_co),
    .acc_q       (acc_q),
    .carry_q     (carry_q),
    .busy        (busy)
  );

  typedef struct {
    logic [2:0] code;
    logic       ci;
    logic [7:0] acc;
    logic       c;
  } res_t;

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         exec_cyc = 0;
  int         waits = 0;
  int         wcnt  = 0;
  logic       stray = 1'b0;
  logic       pr_req;
  logic       pr_cap;
  logic [7:0] mem [256];
  logic [7:0] pa;
  logic [7:0] fq [$];
  res_t       rq [$];
  res_t       pexp;
  logic       pend = 1'b0;
  logic [8:0] alu_t;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One-byte instruction with its hand-computed EXEC code, carry-in and result
  task automatic emit1(input logic [7:0] b, input logic [2:0] code, input logic ci,
                       input logic [7:0] acc, input logic c);
    res_t e;
    mem[pa] = b;
    fq.push_back(pa);
    pa = pa + 8'd1;
    e.code = code; e.ci = ci; e.acc = acc; e.c = c;
    rq.push_back(e);
  endtask

  // Two-byte system instruction; the ALU sits on its idle code during EXEC
  task automatic emit2(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] acc, input logic c);
    res_t e;
    mem[pa] = b0;
    fq.push_back(pa);
    pa = pa + 8'd1;
    mem[pa] = b1;
    fq.push_back(pa);
    pa = pa + 8'd1;
    e.code = 3'd6; e.ci = 1'b0; e.acc = acc; e.c = c;
    rq.push_back(e);
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Reference ALU
  always_comb begin
    alu_t = 9'h000;
    case (alu_code)
      3'd0: alu_t = {1'b0, alu_a} + {1'b0, alu_r} + {8'h00, alu_ci};
      3'd1: alu_t = {1'b0, alu_a} - {1'b0, alu_r} - {8'h00, alu_ci};
      3'd2: alu_t = {1'b0, alu_a & alu_r};
      3'd3: alu_t = {1'b0, alu_a | alu_r};
      3'd4: alu_t = {1'b0, alu_a ^ alu_r};
      3'd5: alu_t = {1'b0, ~alu_a};
      3'd6: alu_t = {1'b0, alu_r};
      default: alu_t = 9'h000;
    endcase
    alu_out = alu_t[7:0];
    alu_co  = alu_t[8];
  end

  // Program memory with programmable wait states and optional stray valids
  always @(posedge clk) begin
    pr_req = instr_req;
    pr_cap = instr_req & instr_valid;
    #1;
    if (!instr_req || !pr_req || pr_cap) wcnt = 0;
    else wcnt++;
    if (instr_req) begin
      instr_valid = (wcnt >= waits);
      instr_data  = mem[instr_addr];
    end else begin
      instr_valid = stray;
      instr_data  = 8'hFF;
    end
  end

  // Scoreboard: fetch addresses on capture, ALU controls in EXEC, results after
  always @(negedge clk) begin
    res_t e;
    if (pend) begin
      chk("wb_acc", acc_q, pexp.acc);
      chk("wb_carry", carry_q, pexp.c);
      pend = 1'b0;
    end
    if (rst_n && instr_req && instr_valid) begin
      chk("fetch_expected", (fq.size() > 0), 1);
      if (fq.size() > 0) chk("fetch_addr", instr_addr, fq.pop_front());
    end
    if (rst_n && busy && !instr_req) begin
      exec_cyc = cyc;
      chk("exec_expected", (rq.size() > 0), 1);
      if (rq.size() > 0) begin
        e = rq.pop_front();
        chk("exec_alu_code", alu_code, e.code);
        chk("exec_alu_ci", alu_ci, e.ci);
        pexp = e;
        pend = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst_n = 1'b0; run = 1'b0; instr_valid = 1'b0; instr_data = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_req", instr_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_code", alu_code, 6);
    chk("rst_alu_ci", alu_ci, 0);
    chk("rst_acc", acc_q, 0);
    chk("rst_carry", carry_q, 0);
    chk("rst_addr", instr_addr, 8'h00);

    // Main program, zero-wait memory
    pa = 8'h00;
    emit2(8'hE8, 8'h05, 8'h05, 1'b0);   // LDI 05
    emit1(8'hE1, 3'd6, 1'b0, 8'h05, 1'b0); // ST R1
    emit2(8'hE8, 8'hFB, 8'hFB, 1'b0);   // LDI FB
    emit1(8'h01, 3'd0, 1'b0, 8'h00, 1'b1); // ADD R1
    emit1(8'h11, 3'd0, 1'b1, 8'h06, 1'b0); // ADDC R1
    emit2(8'hE8, 8'h03, 8'h03, 1'b0);   // LDI 03
    emit1(8'h21, 3'd1, 1'b0, 8'hFE, 1'b1); // SUB R1
    emit1(8'h41, 3'd2, 1'b0, 8'h04, 1'b1); // AND R1
    emit2(8'hF8, 8'h40, 8'h04, 1'b1);   // JC 40, taken
    pa = 8'h40;
    emit2(8'hE8, 8'h00, 8'h00, 1'b1);   // LDI 00
    emit1(8'h01, 3'd0, 1'b0, 8'h05, 1'b0); // ADD R1
    emit2(8'hF0, 8'h10, 8'h05, 1'b0);   // JMP 10
    pa = 8'h10;
    emit2(8'hF8, 8'h40, 8'h05, 1'b0);   // JC 40, not taken -> 12
    emit1(8'hA1, 3'd5, 1'b0, 8'hFA, 1'b0); // NOT
    emit1(8'hC1, 3'd6, 1'b0, 8'h05, 1'b0); // LD R1
    emit1(8'hE2, 3'd6, 1'b0, 8'h05, 1'b0); // ST R2
    emit2(8'hE8, 8'hF0, 8'hF0, 1'b0);   // LDI F0
    emit1(8'h82, 3'd4, 1'b0, 8'hF5, 1'b0); // XOR R2
    emit2(8'hF0, 8'hFF, 8'hF5, 1'b0);   // JMP FF
    pa = 8'hFF;
    emit1(8'h62, 3'd3, 1'b0, 8'hF5, 1'b0); // OR R2 at FF, pc wraps

    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) run = 1'b1;
    for (int i = 0; i < 400 && !(instr_req && instr_addr == 8'hFF); i++) @(negedge clk);
    chk("reach_ff_req", instr_req, 1);
    chk("reach_ff_addr", instr_addr, 8'hFF);
    run = 1'b0;   // dropped during FETCH: instruction still completes
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    chk("stop_busy", busy, 0);
    chk("stop_req", instr_req, 0);
    chk("wrap_addr", instr_addr, 8'h00);
    chk("prog_left", fq.size() + rq.size(), 0);

    // Stray valids in IDLE are ignored
    stray = 1'b1;
    repeat (3) @(negedge clk);
    chk("stray_acc", acc_q, 8'hF5);
    chk("stray_addr", instr_addr, 8'h00);
    chk("stray_busy", busy, 0);
    stray = 1'b0;

    // Three wait states, then reset during the operand wait
    waits = 3;
    fq.push_back(8'h00);
    run = 1'b1;
    for (int i = 0; i < 10 && !instr_req; i++) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("wait_req", instr_req, 1);
      chk("wait_addr", instr_addr, 8'h00);
      @(negedge clk);
    end
    chk("oper_req", instr_req, 1);
    chk("oper_addr", instr_addr, 8'h01);
    #2 rst_n = 1'b0;
    run = 1'b0;
    #1;
    chk("arst_req", instr_req, 0);
    chk("arst_busy", busy, 0);
    chk("arst_addr", instr_addr, 8'h00);
    chk("arst_acc", acc_q, 8'h00);
    chk("arst_alu_code", alu_code, 6);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Restart from RESET_PC, zero wait, stray valids in IDLE/EXEC
    waits = 0;
    stray = 1'b1;
    pa = 8'h00;
    emit2(8'hE8, 8'h05, 8'h05, 1'b0);
    emit1(8'hE1, 3'd6, 1'b0, 8'h05, 1'b0);
    emit2(8'hE8, 8'hFB, 8'hFB, 1'b0);
    emit1(8'h01, 3'd0, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    run = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 40 && !(instr_req && instr_addr == 8'h05); i++) @(negedge clk);
    run = 1'b0;
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    // IDLE->FETCH edge, then LDI(3)+ST(2)+LDI(3); ADD's EXEC is the 10th cycle
    chk("add_exec_cycle", exec_cyc - c0, 10);
    chk("end_busy", busy, 0);
    chk("end_addr", instr_addr, 8'h06);
    chk("end_acc", acc_q, 8'h00);
    chk("end_carry", carry_q, 1);
    chk("end_left", fq.size() + rq.size(), 0);
    stray = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
